logo_loader: RTL and testbench



---
 rtl/logo_loader.sv | 126 ++++++++++++
 tb/tb_logo_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logo_loader.sv
// logo_loader: boot-time copy of the logo image from the logo memory into VRAM.
// One byte per READ/LATCH/REQ pass; each byte is handed to the VRAM arbiter
// over a req/ack handshake. Optional running checksum of accepted writes is
// enabled by defining LOGO_LOADER_CHECKSUM_EN; otherwise checksum is tied 0.
module logo_loader #(
    parameter int unsigned LENGTH     = 16384,
    parameter logic [16:0] VRAM_BASE  = 17'h00000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [13:0] logo_addr,
    input  logic [7:0]  logo_q,
    output logic        vram_req,
    input  logic        vram_ack,
    output logic [16:0] vram_addr,
    output logic [7:0]  vram_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    localparam int unsigned IDX_W    = 15;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_REQ,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] index;
    logic             auto_pend;

    // Sequencer: logo_addr is loaded on entry to READ so the memory sees it
    // for the whole READ cycle and logo_q is valid in LATCH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            index     <= '0;
            auto_pend <= AUTO_START;
            logo_addr <= '0;
            vram_req  <= 1'b0;
            vram_addr <= VRAM_BASE;
            vram_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || auto_pend) begin
                        auto_pend <= 1'b0;
                        index     <= '0;
                        logo_addr <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    vram_data <= logo_q;
                    vram_addr <= VRAM_BASE + 17'(index);
                    vram_req  <= 1'b1;
                    state     <= S_REQ;
                end
                S_REQ: begin
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        if (index == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            index     <= index + IDX_W'(1);
                            logo_addr <= 14'(index + IDX_W'(1));
                            state     <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        index     <= '0;
                        logo_addr <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_READ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LOGO_LOADER_CHECKSUM_EN
    logic        copy_start;
    logic [15:0] sum_q;

    assign copy_start = ((state == S_IDLE) && (start || auto_pend)) ||
                        ((state == S_DONE) && start);

    // Running byte sum of accepted writes, cleared whenever a copy starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (copy_start) begin
            sum_q <= '0;
        end else if (vram_req && vram_ack) begin
            sum_q <= sum_q + 16'(vram_data);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_logo_loader.sv
// tb_logo_loader: two loaders on one clock.
//  dut_a: manual start, short image, VRAM base near the top (address wrap).
//  dut_b: auto start, full 16 KB image, reset asserted mid-copy.
// Writes are compared against an image/address model held in the bench.
module tb_logo_loader;

    localparam int unsigned LEN_A  = 20;
    localparam int unsigned LEN_B  = 16384;
    localparam logic [16:0] BASE_A = 17'h1FFFE;
    localparam logic [16:0] BASE_B = 17'h00100;
`ifdef LOGO_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a, start_a, ack_a, req_a, busy_a, done_a;
    logic [13:0] laddr_a;
    logic [7:0]  q_a, data_a;
    logic [16:0] vaddr_a;
    logic [15:0] csum_a;

    logic        rst_b, start_b, ack_b, req_b, busy_b, done_b;
    logic [13:0] laddr_b;
    logic [7:0]  q_b, data_b;
    logic [16:0] vaddr_b;
    logic [15:0] csum_b;

    logic [7:0]  mem_a [16384];
    logic [7:0]  mem_b [16384];

    logo_loader #(.LENGTH(LEN_A), .VRAM_BASE(BASE_A), .AUTO_START(1'b0)) dut_a (
        .clock(clock), .reset_n(rst_a), .start(start_a),
        .logo_addr(laddr_a), .logo_q(q_a),
        .vram_req(req_a), .vram_ack(ack_a), .vram_addr(vaddr_a), .vram_data(data_a),
        .busy(busy_a), .done(done_a), .checksum(csum_a)
    );

    logo_loader #(.LENGTH(LEN_B), .VRAM_BASE(BASE_B), .AUTO_START(1'b1)) dut_b (
        .clock(clock), .reset_n(rst_b), .start(start_b),
        .logo_addr(laddr_b), .logo_q(q_b),
        .vram_req(req_b), .vram_ack(ack_b), .vram_addr(vaddr_b), .vram_data(data_b),
        .busy(busy_b), .done(done_b), .checksum(csum_b)
    );

    // Logo memories with registered read data.
    always @(posedge clock) begin
        q_a <= mem_a[laddr_a];
        q_b <= mem_b[laddr_b];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected write k lands at base + k, modulo the 17-bit VRAM space.
    function automatic logic [16:0] exp_addr(input logic [16:0] base, input int k);
        return base + 17'(k);
    endfunction

    // dut_a ack policy and write monitor: 0 random, 1 five-cycle stall on byte 2, 2 always.
    int          k_a    = 0;
    int          hold_a = 0;
    int          mode_a = 2;
    logic        stall_a = 1'b0;
    logic [16:0] st_addr;
    logic [7:0]  st_data;

    always @(negedge clock) begin
        if (stall_a) begin
            check("a_stall_req", 32'(req_a), 32'd1);
            check("a_stall_addr", 32'(vaddr_a), 32'(st_addr));
            check("a_stall_data", 32'(data_a), 32'(st_data));
        end
        case (mode_a)
            0: ack_a = 1'($urandom_range(0, 1));
            1: begin
                if (req_a && k_a == 2 && hold_a < 5) begin
                    ack_a = 1'b0;
                    hold_a++;
                end else begin
                    ack_a = 1'b1;
                end
            end
            default: ack_a = 1'b1;
        endcase
        stall_a = req_a && !ack_a;
        st_addr = vaddr_a;
        st_data = data_a;
        if (req_a && ack_a) begin
            check("a_wr_addr", 32'(vaddr_a), 32'(exp_addr(BASE_A, k_a)));
            check("a_wr_data", 32'(data_a), 32'(mem_a[k_a % 16384]));
            k_a++;
        end
    end

    // dut_b write monitor; its ack is tied high.
    int k_b = 0;
    always @(negedge clock) begin
        if (req_b) begin
            check("b_wr_addr", 32'(vaddr_b), 32'(exp_addr(BASE_B, k_b)));
            check("b_wr_data", 32'(data_b), 32'(mem_b[k_b % 16384]));
            k_b++;
        end
    end

    logic [15:0] sum_a, sum_b;

    // One copy on dut_a; cycles counts edges from the start-sampling edge to done.
    task automatic run_a(input int mode, input bit inject, output int cycles);
        @(negedge clock);
        mode_a  = mode;
        k_a     = 0;
        hold_a  = 0;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        cycles = 1;
        check("a_start_busy", 32'(busy_a), 32'd1);
        check("a_start_done_clr", 32'(done_a), 32'd0);
        start_a = 1'b0;
        while (!done_a && cycles < 2000) begin
            if (inject) start_a = (cycles % 5 == 2);
            @(posedge clock);
            #1;
            cycles++;
        end
        start_a = 1'b0;
        check("a_done", 32'(done_a), 32'd1);
        check("a_busy_end", 32'(busy_a), 32'd0);
        check("a_write_count", 32'(k_a), 32'(LEN_A));
        check("a_checksum", 32'(csum_a), CSUM_ON ? 32'(sum_a) : 32'd0);
    endtask

    initial begin
        int cyc;
        int guard;

        for (int i = 0; i < 16384; i++) begin
            mem_a[i] = 8'($urandom);
            mem_b[i] = 8'($urandom);
        end
        sum_a = '0;
        for (int i = 0; i < int'(LEN_A); i++) sum_a = sum_a + 16'(mem_a[i]);
        sum_b = '0;
        for (int i = 0; i < int'(LEN_B); i++) sum_b = sum_b + 16'(mem_b[i]);

        rst_a = 1'b0; rst_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        ack_a = 1'b0; ack_b = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst_logo_addr", 32'(laddr_a), 32'd0);
        check("rst_vram_req", 32'(req_a), 32'd0);
        check("rst_vram_addr", 32'(vaddr_a), 32'(BASE_A));
        check("rst_vram_data", 32'(data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_checksum", 32'(csum_a), 32'd0);
        check("rst_b_vram_addr", 32'(vaddr_b), 32'(BASE_B));

        // Manual-start loader must stay idle after reset release.
        @(negedge clock);
        rst_a = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("a_no_autostart", 32'(busy_a), 32'd0);
        check("a_no_writes", 32'(k_a), 32'd0);

        // Random ack with start pulses while busy.
        run_a(0, 1'b1, cyc);

        repeat (10) @(posedge clock);
        #1;
        check("a_done_sticky", 32'(done_a), 32'd1);
        check("a_no_extra_writes", 32'(k_a), 32'(LEN_A));
        check("a_req_idle", 32'(req_a), 32'd0);
        check("a_checksum_hold", 32'(csum_a), CSUM_ON ? 32'(sum_a) : 32'd0);

        // Zero-wait ack: 3 cycles per byte.
        run_a(2, 1'b0, cyc);
        check("a_latency_zero_wait", 32'(cyc), 32'(3 * LEN_A + 1));

        // Byte 2 ack held off five cycles: exactly five cycles longer.
        run_a(1, 1'b0, cyc);
        check("a_latency_stall", 32'(cyc), 32'(3 * LEN_A + 1 + 5));
        check("a_final_logo_addr", 32'(laddr_a), 32'(LEN_A - 1));

        // Auto-start loader: release reset, abort during REQ of byte 100.
        @(negedge clock);
        k_b = 0;
        rst_b = 1'b1;
        guard = 0;
        do begin
            @(posedge clock);
            #1;
            guard++;
        end while (!(req_b && k_b == 100) && guard < 1000);
        check("b_reached_byte100", 32'(k_b), 32'd100);
        check("b_busy_mid", 32'(busy_b), 32'd1);
        rst_b = 1'b0;
        #1;
        check("b_abort_req_low", 32'(req_b), 32'd0);
        check("b_abort_busy", 32'(busy_b), 32'd0);
        check("b_abort_vram_addr", 32'(vaddr_b), 32'(BASE_B));
        check("b_abort_checksum", 32'(csum_b), 32'd0);
        k_b = 0;
        @(negedge clock);
        @(negedge clock);
        rst_b = 1'b1;

        guard = 0;
        do begin
            @(posedge clock);
            #1;
            guard++;
        end while (!req_b && guard < 20);
        check("b_first_addr", 32'(vaddr_b), 32'(BASE_B));
        check("b_first_data", 32'(data_b), 32'(mem_b[0]));

        guard = 0;
        while (!done_b && guard < 3 * int'(LEN_B) + 100) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check("b_done", 32'(done_b), 32'd1);
        check("b_busy_end", 32'(busy_b), 32'd0);
        check("b_write_count", 32'(k_b), 32'(LEN_B));
        check("b_final_logo_addr", 32'(laddr_b), 32'h3FFF);
        check("b_checksum", 32'(csum_b), CSUM_ON ? 32'(sum_b) : 32'd0);

        repeat (4) @(posedge clock);
        #1;
        check("b_checksum_hold", 32'(csum_b), CSUM_ON ? 32'(sum_b) : 32'd0);
        check("b_done_sticky", 32'(done_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
